// File: rtl/pll_clkdiv_multi.sv
// Multi-channel programmable clock divider with a shared lock flag, all on refclk_i.
// Optional feature: define PLL_CLKDIV_SYNC_EN to realign every channel on each reconfiguration.
module pll_clkdiv_multi #(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_W       = 16,
  parameter int DEF_DIV     = 10,
  parameter int LOCK_CYCLES = 16,
  parameter int CH_W        = 4
) (
  input  logic                  refclk_i,
  input  logic                  rst_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [CH_W-1:0]       cfg_chan_i,
  input  logic [DIV_W-1:0]      cfg_div_i,
  input  logic [DIV_W-1:0]      cfg_phase_i,
  output logic [NUM_CLOCKS-1:0] outclk_o,
  output logic [NUM_CLOCKS-1:0] clk_en_o,
  output logic                  locked_o
);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_SETTLE = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam int SET_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0] DEF_DIV_C = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] DIV_TWO   = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

  // Divisors of 0 and 1 behave as 2.
  function automatic logic [DIV_W-1:0] div_eff(input logic [DIV_W-1:0] d);
    return (d < DIV_TWO) ? DIV_TWO : d;
  endfunction

  state_t                  state_q, state_d;
  logic [SET_W-1:0]        settle_q, settle_d;
  logic                    locked_q, locked_d;
  logic                    ready_q, ready_d;
  logic [DIV_W-1:0]        div_q [NUM_CLOCKS];
  logic [DIV_W-1:0]        div_d [NUM_CLOCKS];
  logic [DIV_W-1:0]        cnt_q [NUM_CLOCKS];
  logic [DIV_W-1:0]        cnt_d [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0]   outclk_q, outclk_d;
  logic [NUM_CLOCKS-1:0]   clk_en_q, clk_en_d;
  logic [NUM_CLOCKS-1:0]   hit_s;
  logic                    xfer_s;
  logic                    load_any_s;
  logic [DIV_W-1:0]        new_eff_s;
  logic [DIV_W-1:0]        new_start_s;
`ifdef PLL_CLKDIV_SYNC_EN
  logic [DIV_W-1:0]        phase_q [NUM_CLOCKS];
  logic [DIV_W-1:0]        phase_d [NUM_CLOCKS];
`endif

  // Channel counters, divided clocks, strobes and reconfiguration loads.
  always_comb begin
    xfer_s      = cfg_valid_i && ready_q;
    new_eff_s   = div_eff(cfg_div_i);
    new_start_s = (cfg_phase_i < new_eff_s) ? cfg_phase_i : '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      hit_s[i] = xfer_s && (cfg_chan_i == CH_W'(i));
    end
    load_any_s = |hit_s;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      div_d[i]    = div_q[i];
      outclk_d[i] = (cnt_q[i] < (div_eff(div_q[i]) >> 1));
      clk_en_d[i] = (cnt_q[i] == (div_eff(div_q[i]) - DIV_ONE));
      if (cnt_q[i] >= (div_eff(div_q[i]) - DIV_ONE)) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DIV_ONE;
      end
`ifdef PLL_CLKDIV_SYNC_EN
      phase_d[i] = phase_q[i];
      if (hit_s[i]) begin
        div_d[i]   = cfg_div_i;
        cnt_d[i]   = new_start_s;
        phase_d[i] = cfg_phase_i;
      end else if (load_any_s) begin
        cnt_d[i] = (phase_q[i] < div_eff(div_q[i])) ? phase_q[i] : '0;
      end else begin
        phase_d[i] = phase_q[i];
      end
`else
      // The load takes priority over the wrap computed above.
      if (hit_s[i]) begin
        div_d[i] = cfg_div_i;
        cnt_d[i] = new_start_s;
      end else begin
        div_d[i] = div_q[i];
      end
`endif
    end
  end

  // Lock FSM: settle timer restarts on every accepted channel reconfiguration.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      S_RESET: begin
        state_d  = S_SETTLE;
        settle_d = '0;
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_LOCKED;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      S_LOCKED: begin
        state_d = S_LOCKED;
      end
      default: begin
        state_d  = S_RESET;
        settle_d = '0;
      end
    endcase
    if (load_any_s) begin
      state_d  = S_SETTLE;
      settle_d = '0;
    end else begin
      settle_d = settle_d;
    end
    locked_d = (state_d == S_LOCKED);
    ready_d  = (state_d != S_RESET);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge refclk_i) begin
    if (!rst_i) begin
      state_q  <= S_RESET;
      settle_q <= '0;
      locked_q <= 1'b0;
      ready_q  <= 1'b0;
      outclk_q <= '0;
      clk_en_q <= '0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_q[i] <= DEF_DIV_C;
        cnt_q[i] <= '0;
`ifdef PLL_CLKDIV_SYNC_EN
        phase_q[i] <= '0;
`endif
      end
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      locked_q <= locked_d;
      ready_q  <= ready_d;
      outclk_q <= outclk_d;
      clk_en_q <= clk_en_d;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
`ifdef PLL_CLKDIV_SYNC_EN
        phase_q[i] <= phase_d[i];
`endif
      end
    end
  end

  assign outclk_o    = outclk_q;
  assign clk_en_o    = clk_en_q;
  assign locked_o    = locked_q;
  assign cfg_ready_o = ready_q;

endmodule

// File: tb/tb_pll_clkdiv_multi.sv
// Self-checking bench for pll_clkdiv_multi: directed table, hand sequences and random traffic
// compared every cycle against an arithmetic phase-origin model.
module tb_pll_clkdiv_multi;
  localparam int NC = 4;
  localparam int DW = 16;
  localparam int DEFD = 10;
  localparam int LC = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [CW-1:0] cfg_chan = '0;
  logic [DW-1:0] cfg_div = '0;
  logic [DW-1:0] cfg_phase = '0;
  logic          cfg_ready;
  logic          locked;
  logic [NC-1:0] outclk;
  logic [NC-1:0] clk_en;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pll_clkdiv_multi #(
    .NUM_CLOCKS(NC), .DIV_W(DW), .DEF_DIV(DEFD), .LOCK_CYCLES(LC), .CH_W(CW)
  ) dut (
    .refclk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_chan_i(cfg_chan), .cfg_div_i(cfg_div), .cfg_phase_i(cfg_phase),
    .outclk_o(outclk), .clk_en_o(clk_en), .locked_o(locked)
  );

  // Model: edge count k since release; each channel's count is (start + k - origin) mod divisor.
  int k;
  int anchor;
  int org [NC];
  int st  [NC];
  int ef  [NC];
  int ph  [NC];
  logic [NC-1:0] e_out;
  logic [NC-1:0] e_en;
  logic e_lock;
  logic e_rdy;

  function automatic int effd(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_edge();
    int p;
    int c;
    if (!rst) begin
      k = 0;
      anchor = 1;
      for (int i = 0; i < NC; i++) begin
        org[i] = 0; st[i] = 0; ef[i] = effd(DEFD); ph[i] = 0;
      end
      e_out = '0; e_en = '0; e_lock = 1'b0; e_rdy = 1'b0;
    end else begin
      k = k + 1;
      for (int i = 0; i < NC; i++) begin
        p = (st[i] + (k - 1) - org[i]) % ef[i];
        e_out[i] = (p < ef[i] / 2);
        e_en[i]  = (p == ef[i] - 1);
      end
      if (cfg_valid && (k - 1 >= 1) && (int'(cfg_chan) < NC)) begin
        c = int'(cfg_chan);
        ph[c] = int'(cfg_phase);
        ef[c] = effd(int'(cfg_div));
`ifdef PLL_CLKDIV_SYNC_EN
        for (int i = 0; i < NC; i++) begin
          org[i] = k;
          st[i] = (ph[i] < ef[i]) ? ph[i] : 0;
        end
`else
        org[c] = k;
        st[c] = (ph[c] < ef[c]) ? ph[c] : 0;
`endif
        anchor = k;
      end
      e_lock = ((k - anchor) >= LC);
      e_rdy = 1'b1;
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("outclk", int'(outclk), int'(e_out));
    check("clk_en", int'(clk_en), int'(e_en));
    check("locked", int'(locked), int'(e_lock));
    check("cfg_ready", int'(cfg_ready), int'(e_rdy));
  endtask

  task automatic cfg(input int ch, input int dv, input int phs);
    cfg_valid = 1'b1;
    cfg_chan = CW'(ch);
    cfg_div = DW'(dv);
    cfg_phase = DW'(phs);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic edges_to_lock(output int n);
    n = 0;
    while (!locked && n < 60) begin
      step();
      n++;
    end
  endtask

  task automatic measure(input int c, output int hi, output int lo);
    int guard;
    guard = 0;
    while (outclk[c] !== 1'b0 && guard < 40) begin step(); guard++; end
    while (outclk[c] !== 1'b1 && guard < 80) begin step(); guard++; end
    hi = 0;
    while (outclk[c] === 1'b1 && hi < 40) begin step(); hi++; end
    lo = 0;
    while (outclk[c] === 1'b0 && lo < 40) begin step(); lo++; end
  endtask

  typedef struct {
    int chan;
    int dv;
    int phs;
    int hi;
    int lo;
  } vec_t;

  initial begin
    vec_t tbl [7];
    int n;
    int hi;
    int lo;
    int ens;

    tbl[0] = '{1, 3, 0, 1, 2};
    tbl[1] = '{2, 0, 0, 1, 1};
    tbl[2] = '{2, 1, 0, 1, 1};
    tbl[3] = '{3, 7, 3, 3, 4};
    tbl[4] = '{0, 10, 5, 5, 5};
    tbl[5] = '{1, 2, 1, 1, 1};
    tbl[6] = '{3, 12, 20, 6, 6};

    // Reset held low for three edges, then released.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("reset_outclk", int'(outclk), 0);
    check("reset_locked", int'(locked), 0);
    rst = 1'b1;
    edges_to_lock(n);
    check("lock_edge_after_release", n, LC + 1);

    // Default divisor: 5 high / 5 low, one strobe per period.
    measure(0, hi, lo);
    check("def_high", hi, 5);
    check("def_low", lo, 5);
    ens = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (clk_en[0]) ens++;
    end
    check("def_strobes_per_20", ens, 2);

    // Reconfigure ch1 while locked: lock drops next edge, returns 16 edges later.
    cfg(1, 3, 0);
    check("lock_drop", int'(locked), 0);
    edges_to_lock(n);
    check("relock_edges", n, LC);

    // Out-of-range channel: accepted, nothing changes, lock held.
    check("ready_before_bad_chan", int'(cfg_ready), 1);
    cfg(15, 5, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("lock_held_bad_chan", int'(locked), 1);
    end

    // Directed divisor / phase table.
    for (int t = 0; t < 7; t++) begin
      cfg(tbl[t].chan, tbl[t].dv, tbl[t].phs);
      measure(tbl[t].chan, hi, lo);
      check("tbl_high", hi, tbl[t].hi);
      check("tbl_low", lo, tbl[t].lo);
    end

    // Divisor 1 on ch2: strobe every second cycle.
    cfg(2, 1, 0);
    step();
    ens = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (clk_en[2]) ens++;
    end
    check("div1_strobes_per_10", ens, 5);

    // Reset during settle, 8 cycles after a load.
    cfg(0, 6, 2);
    for (int i = 0; i < 8; i++) step();
    rst = 1'b0;
    step();
    check("midsettle_rst_outclk", int'(outclk), 0);
    check("midsettle_rst_clk_en", int'(clk_en), 0);
    check("midsettle_rst_ready", int'(cfg_ready), 0);
    step();
    step();
    rst = 1'b1;
    edges_to_lock(n);
    check("lock_after_midsettle_rst", n, LC + 1);

`ifdef PLL_CLKDIV_SYNC_EN
    cfg(0, 4, 0);
    cfg(1, 4, 0);
    cfg(1, 4, 2);
    for (int i = 0; i < 12; i++) step();
`endif

    // Random traffic including invalid channels and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      cfg_valid = ($urandom_range(0, 19) == 0);
      cfg_chan  = CW'($urandom_range(0, 5));
      cfg_div   = DW'($urandom_range(0, 12));
      cfg_phase = DW'($urandom_range(0, 14));
      rst       = ($urandom_range(0, 299) != 0);
      step();
    end
    cfg_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
